// File: rtl/seq_divider.sv
// Iterative signed divider: restoring shift-subtract, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             zero;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;
  logic             div_zero;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // shifted is the WIDTH+1 bit partial remainder; after a restoring
  // step it is always below |divisor|, so WIDTH bits of state suffice.
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    ge      = shifted >= {1'b0, dvsr};
    diff    = shifted[WIDTH-1:0] - dvsr;
    step_r  = ge ? diff : shifted[WIDTH-1:0];
    step_q  = {q[WIDTH-2:0], ge};
  end

  assign div_zero = (divisor == '0);
  assign busy     = (state == CALC) || (state == FIX);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
            zero  <= div_zero;
            dvsr  <= mag(divisor);
            // A zero divisor keeps the raw dividend: it is the remainder.
            q     <= div_zero ? dividend : mag(dividend);
            r     <= '0;
            cnt   <= CNT_INIT;
            state <= div_zero ? FIX : CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          r   <= step_r;
          q   <= step_q;
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero) begin
            quotient  <= '1;
            remainder <= q;
          end else begin
            quotient  <= neg_q ? -q : q;
            remainder <= neg_r ? -r : r;
          end
          div_by_zero <= zero;
          state       <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus hand-written
// sequences for busy-start, operand changes, back-to-back and reset abort.
module tb_seq_divider;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen,
  // with lat = edges counted from the accepting edge (inclusive).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    logic got;
    got      = 1'b0;
    lat      = 0;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  initial begin
    int lat;
    int npulse;
    logic got;

    vt[0]  = '{32'd3360, 32'd96, 32'd35, 32'd0, 1'b0, LAT};
    vt[1]  = '{-32'sd300, 32'd20, -32'sd15, 32'd0, 1'b0, LAT};
    vt[2]  = '{-32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, LAT};
    vt[3]  = '{32'd7, -32'sd2, -32'sd3, 32'd1, 1'b0, LAT};
    vt[4]  = '{-32'sd7, -32'sd2, 32'd3, -32'sd1, 1'b0, LAT};
    vt[5]  = '{32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 2};
    vt[6]  = '{32'd10, 32'd3, 32'd3, 32'd1, 1'b0, LAT};
    vt[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, LAT};
    vt[8]  = '{32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, LAT};
    vt[9]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0, LAT};
    vt[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0, 1'b0, LAT};
    vt[11] = '{-32'sd1234, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FB2E, 1'b1, 2};
    vt[12] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, LAT};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      do_op(vt[i].a, vt[i].b, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_q", i), quotient, vt[i].q);
      chk($sformatf("v%0d_r", i), remainder, vt[i].r);
      chk($sformatf("v%0d_dz", i), {31'd0, div_by_zero}, {31'd0, vt[i].dz});
    end
    @(negedge clk);
    chk("done_pulse_len", {31'd0, done}, 32'd0);

    // Busy-start ignored, operand changes ignored, back-to-back start.
    start    = 1'b1;
    dividend = 32'd35427456;
    divisor  = 32'd9648;
    got      = 1'b0;
    lat      = 0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        chk("s5_busy", {31'd0, busy}, 32'd1);
      end
      if (i == 10) begin
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd5;
      end
      if (i == 11) start = 1'b0;
      if (i == 15) begin
        dividend = 32'd1;
        divisor  = 32'd3;
      end
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk("s5_lat", 32'(lat), 32'(LAT));
    chk("s5_q", quotient, 32'd3672);
    chk("s5_r", remainder, 32'd0);
    do_op(32'd100, 32'd7, lat);
    chk("b2b_lat", 32'(lat), 32'(LAT));
    chk("b2b_q", quotient, 32'd14);
    chk("b2b_r", remainder, 32'd2);

    // Reset in the middle of a division aborts it with no done.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd35427456;
    divisor  = 32'd9648;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("abort_no_done", 32'(npulse), 32'd0);
    do_op(32'd9, 32'd4, lat);
    chk("post_lat", 32'(lat), 32'(LAT));
    chk("post_q", quotient, 32'd2);
    chk("post_r", remainder, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
